// File: rtl/rom_boot_pkg.sv
// ============================================================================
// Module      : rom_boot_pkg
// Description : Shared state encoding and default widths for the ROM boot
//               sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package rom_boot_pkg;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        WRITE = 2'd1,
        DONE  = 2'd2
    } boot_state_e;

    localparam int unsigned DEF_ADDR_WIDTH = 10;
    localparam int unsigned DEF_DATA_WIDTH = 16;
    localparam int unsigned DEF_BOOT_WORDS = 1024;

endpackage

`default_nettype wire

// File: rtl/rom_boot_sequencer.sv
// ============================================================================
// Module      : rom_boot_sequencer
// Description : Copies BOOT_WORDS words from a combinational ROM into
//               instruction memory, then releases the core. Optional checksum
//               check compiled in by ROM_BOOT_SEQUENCER_CHECKSUM_EN.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rom_boot_sequencer
    import rom_boot_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int BOOT_WORDS = DEF_BOOT_WORDS
) (
    input  logic                  clk,
    input  logic                  async_rst,
    input  logic                  Reboot,
    output logic [ADDR_WIDTH-1:0] RomAddress,
    input  logic [DATA_WIDTH-1:0] RomValue,
    output logic                  IMemWriteValid,
    input  logic                  IMemWriteReady,
    output logic [ADDR_WIDTH-1:0] IMemWriteAddress,
    output logic [DATA_WIDTH-1:0] IMemWriteData,
    output logic                  CoreResetHold,
    output logic                  BootDone,
    input  logic [DATA_WIDTH-1:0] ExpectedChecksum,
    output logic                  BootError
);

    localparam logic [ADDR_WIDTH-1:0] C_LAST_WORD = ADDR_WIDTH'(BOOT_WORDS - 1);

    boot_state_e           state_q;
    logic [ADDR_WIDTH-1:0] count_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q;
    logic                  done_q;
    logic                  hold_q;

    logic xfer;
    logic last_xfer;
    logic reboot_ok;
    logic err_d;

    assign xfer      = valid_q & IMemWriteReady;
    assign last_xfer = xfer & (count_q == C_LAST_WORD);
    assign reboot_ok = (state_q == DONE) & Reboot;

`ifdef ROM_BOOT_SEQUENCER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0] sum_q;
    logic [DATA_WIDTH-1:0] sum_d;
    logic                  err_q;

    // The last word joins the sum on the same edge the verdict is taken.
    assign sum_d = sum_q + data_q;
    assign err_d = (sum_d != ExpectedChecksum);

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else if (reboot_ok) begin
            sum_q <= '0;
            err_q <= 1'b0;
        end else if (xfer) begin
            sum_q <= sum_d;
            if (last_xfer) begin
                err_q <= err_d;
            end
        end
    end

    assign BootError = err_q;
`else
    logic unused_expected;

    assign unused_expected = ^ExpectedChecksum;
    assign err_d           = 1'b0;
    assign BootError       = 1'b0;
`endif

    always_ff @(posedge clk or posedge async_rst) begin
        if (async_rst) begin
            state_q <= LOAD;
            count_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            done_q  <= 1'b0;
            hold_q  <= 1'b1;
        end else begin
            case (state_q)
                LOAD: begin
                    data_q  <= RomValue;
                    valid_q <= 1'b1;
                    state_q <= WRITE;
                end
                WRITE: begin
                    if (xfer) begin
                        valid_q <= 1'b0;
                        if (last_xfer) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                            hold_q  <= err_d;
                        end else begin
                            count_q <= count_q + 1'b1;
                            state_q <= LOAD;
                        end
                    end
                end
                DONE: begin
                    if (Reboot) begin
                        count_q <= '0;
                        done_q  <= 1'b0;
                        hold_q  <= 1'b1;
                        state_q <= LOAD;
                    end
                end
                default: begin
                    state_q <= LOAD;
                    valid_q <= 1'b0;
                    done_q  <= 1'b0;
                    hold_q  <= 1'b1;
                end
            endcase
        end
    end

    assign RomAddress       = count_q;
    assign IMemWriteValid   = valid_q;
    assign IMemWriteAddress = count_q;
    assign IMemWriteData    = data_q;
    assign BootDone         = done_q;
    assign CoreResetHold    = hold_q;

endmodule

`default_nettype wire

// File: doc/rom_boot_sequencer.md
ROM_BOOT_SEQUENCER -- requirements
Module: rom_boot_sequencer

Interface
REQ-001 SHALL have parameter ADDR_WIDTH, default 10, ROM/instruction-memory word address width.
REQ-002 SHALL have parameter DATA_WIDTH, default 16, instruction word width.
REQ-003 SHALL have parameter BOOT_WORDS, default 1024, number of words copied (range 1..2^ADDR_WIDTH).
REQ-004 SHALL have port clk  input  1  the single system clock; all state is updated on its rising edge.
REQ-005 SHALL have port async_rst  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port Reboot  input  1  single-cycle request to rerun the copy.
REQ-007 SHALL have port RomAddress  output  ADDR_WIDTH  address to the combinational instruction ROM.
REQ-008 SHALL have port RomValue  input  DATA_WIDTH  ROM word, valid in the same cycle as RomAddress.
REQ-009 SHALL have port IMemWriteValid  output  1  write request to instruction memory.
REQ-010 SHALL have port IMemWriteReady  input  1  instruction memory accepts the write.
REQ-011 SHALL have port IMemWriteAddress  output  ADDR_WIDTH  write address.
REQ-012 SHALL have port IMemWriteData  output  DATA_WIDTH  write data.
REQ-013 SHALL have port CoreResetHold  output  1  holds the core in reset while high.
REQ-014 SHALL have port BootDone  output  1  copy has completed.
REQ-015 SHALL have port ExpectedChecksum  input  DATA_WIDTH  reference sum for the checksum feature.
REQ-016 SHALL have port BootError  output  1  checksum mismatch.

Function
REQ-017 SHALL implement states LOAD, WRITE and DONE, with a word counter Count of ADDR_WIDTH bits.
REQ-018 SHALL drive RomAddress = Count in all states.
REQ-019 In LOAD, SHALL latch RomValue into DataReg and move to WRITE on the next edge, taking exactly one cycle.
REQ-020 In WRITE, SHALL assert IMemWriteValid=1, with IMemWriteAddress=Count and IMemWriteData=DataReg.
REQ-021 SHALL hold valid, address and data stable while IMemWriteValid=1 and IMemWriteReady=0.
REQ-022 A transfer SHALL occur on an edge where IMemWriteValid=1 and IMemWriteReady=1.
REQ-023 On a transfer with Count==BOOT_WORDS-1, SHALL move to DONE.
REQ-024 On any other transfer, SHALL increment Count and move to LOAD.
REQ-025 With IMemWriteReady held high, a full copy SHALL take 2*BOOT_WORDS cycles.
REQ-026 IMemWriteValid SHALL be 0 in LOAD and in DONE.
REQ-027 In DONE, SHALL drive BootDone=1 and CoreResetHold=BootError.
REQ-028 In LOAD and WRITE, SHALL drive BootDone=0 and CoreResetHold=1.
REQ-029 Reboot SHALL be honoured only in DONE: on it, clear Count, clear BootError and the checksum, and go to LOAD.
REQ-030 Reboot SHALL be ignored in LOAD and WRITE.
REQ-031 Count arithmetic SHALL be unsigned and SHALL never wrap: the terminal compare precedes the increment.

Reset
REQ-032 async_rst high SHALL immediately force LOAD, Count=0 and DataReg=0.
REQ-033 While async_rst is high, outputs SHALL be IMemWriteValid=0, CoreResetHold=1, BootDone=0, BootError=0, checksum=0.
REQ-034 Reset asserted mid-copy SHALL abandon the pending write with no partial-state retention.
REQ-035 The copy SHALL restart from word 0 on the first edge after reset release.

Configuration
REQ-036 The checksum feature SHALL be compiled in by macro ROM_BOOT_SEQUENCER_CHECKSUM_EN.
REQ-037 With ROM_BOOT_SEQUENCER_CHECKSUM_EN defined, each transfer SHALL add IMemWriteData to a DATA_WIDTH accumulator, modulo 2^DATA_WIDTH.
REQ-038 With the macro defined, on entry to DONE BootError SHALL register (sum+last word != ExpectedChecksum) and hold until reset or Reboot.
REQ-039 Without the macro, BootError SHALL be constant 0, ExpectedChecksum SHALL be unused, and no accumulator SHALL exist.

Structure
REQ-040 A shared package rom_boot_pkg SHALL hold the state enum (LOAD, WRITE, DONE) and default width constants.
REQ-041 No sub-module SHALL be used; the checksum accumulator SHALL be inline logic within the macro guard.

Verification
REQ-042 BOOT_WORDS=37, ROM model word0=16'hD188 and word36=16'hA00F, ready always 1: exactly 37 writes, addresses 0..36 in order, data matches the ROM, BootDone high at cycle 74, CoreResetHold low at cycle 74.
REQ-043 Ready low for 5 cycles during the write of word 3: valid, address 3 and data stay constant for all 5 cycles, and word 4 is not read early.
REQ-044 async_rst pulsed during the write of word 10: valid drops immediately, and the copy restarts at address 0 after release.
REQ-045 Reboot pulsed in WRITE is ignored; Reboot pulsed in DONE produces a second full 37-word copy with CoreResetHold high throughout.
REQ-046 Macro on, ExpectedChecksum equal to the true 16-bit sum: BootError=0 and the core is released; ExpectedChecksum = sum^16'h0001: BootError=1 and CoreResetHold stays 1.
REQ-047 BOOT_WORDS=1: one write to address 0, then DONE at cycle 2.
